fsm_ctx_arbiter: RTL and testbench
==================================

Name: fsm_ctx_arbiter

Overview:
- Time-multiplexes one instance of the team's 6-state symbol FSM among NUM_REQ requesters.
- Each requester owns a private 3-bit state context; the block holds these contexts.
- Each cycle the round-robin arbiter with burst lock selects at most one requester, applies its 2-bit symbol to that requester's context, and returns the new state and Moore output one cycle later.
- Sits between symbol producers and downstream consumers of the per-stream FSM output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BURST_MAX, 4, max symbols accepted per grant before forced rotation (1..15).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  symbol valid per requester
- req_sym  input  2*NUM_REQ  symbol, requester i at [2i+1:2i]
- req_last  input  NUM_REQ  symbol ends requester's burst
- req_ready  output  NUM_REQ  one-hot accept, combinational
- ctx_clear  input  NUM_REQ  synchronous clear of requester context to S0
- rsp_valid  output  1  registered response strobe
- rsp_id  output  $clog2(NUM_REQ)  requester of response
- rsp_state  output  3  context state after transition
- rsp_out  output  1  Moore output of rsp_state

Behaviour:
- States: S0=0, S1=1, S2=2, S3=3, S4=4, S5=5. Codes 6/7 are illegal and map to next state S0.
- Transition table (current: sym0,sym1,sym2,sym3):
  - S0: S0,S1,S2,S3
  - S1: S0,S3,S1,S5
  - S2: S1,S3,S2,S4
  - S3: S1,S0,S4,S5
  - S4: S0,S1,S2,S5
  - S5: S1,S4,S0,S5
- Output is 1 in S0, S2, S4; 0 otherwise.
- Reset: all contexts S0, rr pointer 0, lock clear, burst count 0, rsp_valid/rsp_id/rsp_state/rsp_out 0.
- Arbitration when unlocked: first i with req_valid[i] && !ctx_clear[i], searching from rr pointer upward with wrap. Winner becomes the grant and lock sets.
- Arbitration when locked: grant stays on the locked requester.
  - If its req_valid is low or its ctx_clear is high, lock releases that cycle with no accept.
  - Release moves the rr pointer to grant+1 mod NUM_REQ; re-arbitration happens the next cycle.
- Accept: req_ready[g]=1 iff granted && req_valid[g] && !ctx_clear[g]. At most one bit is set.
- On accept:
  - ctx[g] <= next(ctx[g], sym).
  - Burst count increments.
  - Next cycle: rsp_valid=1, rsp_id=g, rsp_state = new ctx, rsp_out = output(new ctx). Latency 1.
  - There is no response backpressure.
- Lock release after accept: release when req_last[g] or burst count reaches BURST_MAX. Then rr pointer <= g+1 wrapped, burst count <= 0.
- No accept: rsp_valid=0 next cycle. rsp_id/state/out hold their previous values.
- ctx_clear[i] sets ctx[i] to S0 next cycle, for any i, and takes priority over an accept for the same i (no accept, ready low). Clears on other requesters proceed in parallel with the accept.
- Single active requester: re-granted immediately after each forced release. No bubble beyond the release cycle, when it is locked.
- NUM_REQ not a power of two: rr pointer wraps at NUM_REQ-1 explicitly.
- Reset mid-burst: in-flight response is dropped and all state returns to reset values.

Optional Feature:
- Macro FSM_CTX_ARB_STATS_EN.
- When defined, adds:
  - Port stats_sel (input, $clog2(NUM_REQ)).
  - Port stats_cnt (output, 16).
  - A per-requester 16-bit saturating count of accepted symbols; it holds at 16'hFFFF.
  - stats_cnt is combinationally cnt[stats_sel].
  - ctx_clear[i] zeroes cnt[i]. Reset zeroes all counts.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fsm_ctx_pkg:
  - State typedef and encodings S0..S5.
  - Function fsm_next(state, sym) implementing the table.
  - Function fsm_out(state).
- Sub-module rr_lock_arbiter: request vector, lock/release inputs, grant index, grant valid, rr pointer. The context/response datapath stays in the top.

Test Plan:
- Reset, then requester 0 sends syms 1,1,2 (last on 3rd) -> responses: (id0,S1,out0), (id0,S3,out0), (id0,S4,out1) on consecutive cycles.
- Req 0 and req 2 both valid continuously, no last, BURST_MAX=4 -> 4 accepts for id0, one release cycle, then 4 accepts for id2, alternating.
- Interleave: req1 takes sym 3 (S0->S3), req3 takes sym 2 (S0->S2), req1 takes sym 0 -> req1 context is S1 (out0). Independent contexts confirmed.
- ctx_clear[1] asserted while req1 valid and granted -> req_ready[1]=0, lock released; next cycle ctx1=S0 and next req1 sym 0 returns (S0,out1).
- Drive sym 3 repeatedly on one requester from S0 -> S3, S5, S5; rsp_out 0, 0, 0. Force ctx to 6 via illegal-injection bench hook -> next accept yields S0.
- With FSM_CTX_ARB_STATS_EN: 70000 accepts on req0 -> stats_cnt(sel0) reads 65535; ctx_clear[0] -> 0.

Source files
------------

// File: rtl/fsm_ctx_pkg.sv
// Shared definitions for the time-multiplexed 6-state symbol FSM: state
// encodings, transition/output functions and a wrap-around index helper.
package fsm_ctx_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t S0 = 3'd0;
    localparam fsm_state_t S1 = 3'd1;
    localparam fsm_state_t S2 = 3'd2;
    localparam fsm_state_t S3 = 3'd3;
    localparam fsm_state_t S4 = 3'd4;
    localparam fsm_state_t S5 = 3'd5;

    localparam int BURST_CNT_W = 4;

    // Codes 6 and 7 are unreachable in normal operation but recover to S0.
    function automatic fsm_state_t fsm_next(input fsm_state_t st, input logic [1:0] sym);
        fsm_state_t nxt;
        nxt = S0;
        case (st)
            S0: case (sym) 2'd0: nxt = S0; 2'd1: nxt = S1; 2'd2: nxt = S2; default: nxt = S3; endcase
            S1: case (sym) 2'd0: nxt = S0; 2'd1: nxt = S3; 2'd2: nxt = S1; default: nxt = S5; endcase
            S2: case (sym) 2'd0: nxt = S1; 2'd1: nxt = S3; 2'd2: nxt = S2; default: nxt = S4; endcase
            S3: case (sym) 2'd0: nxt = S1; 2'd1: nxt = S0; 2'd2: nxt = S4; default: nxt = S5; endcase
            S4: case (sym) 2'd0: nxt = S0; 2'd1: nxt = S1; 2'd2: nxt = S2; default: nxt = S5; endcase
            S5: case (sym) 2'd0: nxt = S1; 2'd1: nxt = S4; 2'd2: nxt = S0; default: nxt = S5; endcase
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    function automatic logic fsm_out(input fsm_state_t st);
        return (st == S0) || (st == S2) || (st == S4);
    endfunction

    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/fsm_ctx_arbiter_arb.sv
// rr_lock_arbiter: round-robin requester selection with a burst lock that holds
// the grant until the datapath signals release or the locked request drops.
module rr_lock_arbiter
    import fsm_ctx_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_release,
    output logic [IDW-1:0]     o_gnt_idx,
    output logic               o_gnt_valid
);

    logic           r_locked;
    logic [IDW-1:0] r_lock_idx;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_idx;
    logic           w_any;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_winner = r_rr_ptr;
        w_any    = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'(wrap_add(32'(r_rr_ptr), k, NUM_REQ));
            if (!w_any && i_req[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign o_gnt_idx   = r_locked ? r_lock_idx : w_winner;
    assign o_gnt_valid = r_locked | w_any;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else if (r_locked) begin
            if (!i_req[r_lock_idx] || i_release) begin
                r_locked <= 1'b0;
                r_rr_ptr <= IDW'(wrap_add(32'(r_lock_idx), 1, NUM_REQ));
            end
        end else if (w_any) begin
            // A single-symbol burst releases in the same cycle it is granted.
            if (i_release) begin
                r_rr_ptr <= IDW'(wrap_add(32'(w_winner), 1, NUM_REQ));
            end else begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_winner;
            end
        end
    end

endmodule

// File: rtl/fsm_ctx_arbiter.sv
// Shares one symbol FSM among NUM_REQ streams, each with a private state context.
// Optional per-requester accept counters are enabled with FSM_CTX_ARB_STATS_EN.
module fsm_ctx_arbiter
    import fsm_ctx_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int BURST_MAX = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [2*NUM_REQ-1:0] i_req_sym,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [NUM_REQ-1:0]   i_ctx_clear,
    output logic                 o_rsp_valid,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [2:0]           o_rsp_state,
    output logic                 o_rsp_out
`ifdef FSM_CTX_ARB_STATS_EN
    ,
    input  logic [IDW-1:0]       i_stats_sel,
    output logic [15:0]          o_stats_cnt
`endif
);

    fsm_state_t             r_ctx [NUM_REQ];
    logic [BURST_CNT_W-1:0] r_burst_cnt;
    logic                   r_rsp_valid;
    logic [IDW-1:0]         r_rsp_id;
    fsm_state_t             r_rsp_state;
    logic                   r_rsp_out;

    logic [NUM_REQ-1:0]     w_req_eligible;
    logic [IDW-1:0]         w_gnt_idx;
    logic                   w_gnt_valid;
    logic                   w_accept;
    logic                   w_release;
    logic [1:0]             w_sym;
    fsm_state_t             w_ctx_next;

    // A pending clear masks the request so it can neither win nor hold a grant.
    assign w_req_eligible = i_req_valid & ~i_ctx_clear;

    rr_lock_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (w_req_eligible),
        .i_release   (w_release),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    assign w_accept   = w_gnt_valid & w_req_eligible[w_gnt_idx];
    assign w_sym      = i_req_sym[{w_gnt_idx, 1'b0} +: 2];
    assign w_ctx_next = fsm_next(r_ctx[w_gnt_idx], w_sym);
    assign w_release  = w_accept &
                        (i_req_last[w_gnt_idx] ||
                         (r_burst_cnt == BURST_CNT_W'(BURST_MAX - 1)));

    always_comb begin
        o_req_ready = '0;
        if (w_accept) o_req_ready[w_gnt_idx] = 1'b1;
    end

    // A granted cycle without accept is always a lock release, so the count restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (w_accept) begin
            r_burst_cnt <= w_release ? '0 : r_burst_cnt + 1'b1;
        end else if (w_gnt_valid) begin
            r_burst_cnt <= '0;
        end
    end

    // NOTE: the context array is reset because every stream must start in S0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_ctx[i] <= S0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_ctx_clear[i]) begin
                    r_ctx[i] <= S0;
                end else if (w_accept && (w_gnt_idx == IDW'(i))) begin
                    r_ctx[i] <= w_ctx_next;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_state <= S0;
            r_rsp_out   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_id    <= w_gnt_idx;
                r_rsp_state <= w_ctx_next;
                r_rsp_out   <= fsm_out(w_ctx_next);
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_state = r_rsp_state;
    assign o_rsp_out   = r_rsp_out;

`ifdef FSM_CTX_ARB_STATS_EN
    logic [15:0] r_stats_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_stats_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_ctx_clear[i]) begin
                    r_stats_cnt[i] <= '0;
                end else if (w_accept && (w_gnt_idx == IDW'(i)) &&
                             (r_stats_cnt[i] != 16'hFFFF)) begin
                    r_stats_cnt[i] <= r_stats_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign o_stats_cnt = r_stats_cnt[i_stats_sel];
`endif

endmodule

// File: tb/tb_fsm_ctx_arbiter.sv
// Directed self-checking bench for fsm_ctx_arbiter (NUM_REQ=4, BURST_MAX=4);
// the stats section is compiled only with FSM_CTX_ARB_STATS_EN.
module tb_fsm_ctx_arbiter;
    import fsm_ctx_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int BURST_MAX = 4;
    localparam int IDW       = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_sym;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   ctx_clear;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [2:0]           rsp_state;
    logic                 rsp_out;
`ifdef FSM_CTX_ARB_STATS_EN
    logic [IDW-1:0]       stats_sel;
    logic [15:0]          stats_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fsm_ctx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (req_valid),
        .i_req_sym   (req_sym),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .i_ctx_clear (ctx_clear),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_state (rsp_state),
        .o_rsp_out   (rsp_out)
`ifdef FSM_CTX_ARB_STATS_EN
        ,
        .i_stats_sel (stats_sel),
        .o_stats_cnt (stats_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input int id,
                             input fsm_state_t st, input logic o);
        check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        check({tag, ".id"},    32'(rsp_id),    32'(id));
        check({tag, ".state"}, 32'(rsp_state), 32'(st));
        check({tag, ".out"},   32'(rsp_out),   32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_sym   = '0;
        req_last  = '0;
        ctx_clear = '0;
    endtask

    task automatic drive(input int id, input logic [1:0] sym, input logic last);
        req_valid[id]      = 1'b1;
        req_sym[2*id +: 2] = sym;
        req_last[id]       = last;
    endtask

    // Transition table and Moore outputs written out independently of the RTL.
    int tbl [6][4] = '{'{0, 1, 2, 3}, '{0, 3, 1, 5}, '{1, 3, 2, 4},
                       '{1, 0, 4, 5}, '{0, 1, 2, 5}, '{1, 4, 0, 5}};
    int out_tbl [6] = '{1, 0, 1, 0, 1, 0};

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_id;
        idle();
`ifdef FSM_CTX_ARB_STATS_EN
        stats_sel = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_rsp("reset", 1'b0, 0, S0, 1'b0);
        check("reset.ready", 32'(req_ready), 32'd0);

        // Burst on requester 0: syms 1,1,2 with last on the third.
        drive(0, 2'd1, 1'b0);
        #1 check("t1.ready", 32'(req_ready), 32'b0001);
        tick(); check_rsp("t1.a", 1'b1, 0, S1, 1'b0);
        drive(0, 2'd1, 1'b0);
        tick(); check_rsp("t1.b", 1'b1, 0, S3, 1'b0);
        drive(0, 2'd2, 1'b1);
        tick(); check_rsp("t1.c", 1'b1, 0, S4, 1'b1);
        idle();
        tick(); check_rsp("t1.idle", 1'b0, 0, S4, 1'b1);

        // Requesters 0 and 2 both streaming: rr pointer sits at 1, so 2 goes first.
        drive(0, 2'd0, 1'b0);
        drive(2, 2'd0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            exp_id = (((c / BURST_MAX) % 2) == 0) ? 2 : 0;
            #1 check("t2.ready", 32'(req_ready), 32'd1 << exp_id);
            tick();
            check("t2.valid", 32'(rsp_valid), 32'd1);
            check("t2.id",    32'(rsp_id),    32'(exp_id));
            check("t2.state", 32'(rsp_state), 32'(S0));
        end
        idle();
        tick(); check("t2.idle", 32'(rsp_valid), 32'd0);

        // Independent contexts on requesters 1 and 3.
        drive(1, 2'd3, 1'b1);
        tick(); check_rsp("t3.r1a", 1'b1, 1, S3, 1'b0);
        idle(); drive(3, 2'd2, 1'b1);
        tick(); check_rsp("t3.r3", 1'b1, 3, S2, 1'b1);
        idle(); drive(1, 2'd0, 1'b1);
        tick(); check_rsp("t3.r1b", 1'b1, 1, S1, 1'b0);
        idle();

        // Clear on the locked requester: no accept, release, context back to S0.
        drive(1, 2'd1, 1'b0);
        tick(); check_rsp("t4.lock", 1'b1, 1, S3, 1'b0);
        ctx_clear[1] = 1'b1;
        #1 check("t4.ready_clr", 32'(req_ready), 32'd0);
        tick(); check_rsp("t4.noacc", 1'b0, 1, S3, 1'b0);
        ctx_clear[1] = 1'b0;
        drive(1, 2'd0, 1'b1);
        #1 check("t4.ready", 32'(req_ready), 32'b0010);
        tick(); check_rsp("t4.after", 1'b1, 1, S0, 1'b1);
        idle();

        // Repeated sym 3 from S0 on requester 2, then a release bubble.
        drive(2, 2'd3, 1'b0);
        tick(); check_rsp("t5.a", 1'b1, 2, S3, 1'b0);
        tick(); check_rsp("t5.b", 1'b1, 2, S5, 1'b0);
        tick(); check_rsp("t5.c", 1'b1, 2, S5, 1'b0);
        idle();
        tick(); check_rsp("t5.rel", 1'b0, 2, S5, 1'b0);

        // Clear on requester 2 proceeds alongside an accept on requester 3.
        drive(3, 2'd0, 1'b1);
        ctx_clear[2] = 1'b1;
        #1 check("t6.ready", 32'(req_ready), 32'b1000);
        tick(); check_rsp("t6.r3", 1'b1, 3, S1, 1'b0);
        idle(); drive(2, 2'd1, 1'b1);
        tick(); check_rsp("t6.r2", 1'b1, 2, S1, 1'b0);
        idle();

        // Transition/output functions, including the illegal codes 6 and 7.
        for (int s = 0; s < 6; s++) begin
            check("fn.out", 32'(fsm_out(3'(s))), 32'(out_tbl[s]));
            for (int y = 0; y < 4; y++)
                check("fn.next", 32'(fsm_next(3'(s), 2'(y))), 32'(tbl[s][y]));
        end
        for (int y = 0; y < 4; y++) begin
            check("fn.ill6", 32'(fsm_next(3'd6, 2'(y))), 32'(S0));
            check("fn.ill7", 32'(fsm_next(3'd7, 2'(y))), 32'(S0));
        end

        // Reset mid-burst drops the response and restores requester 2 to S0.
        drive(2, 2'd1, 1'b0);
        tick(); check_rsp("t7.pre", 1'b1, 2, S3, 1'b0);
        reset = 1'b1;
        #1 check_rsp("t7.rst", 1'b0, 0, S0, 1'b0);
        tick();
        reset = 1'b0;
        req_last[2] = 1'b1;
        tick(); check_rsp("t7.post", 1'b1, 2, S1, 1'b0);
        idle();
        tick();

`ifdef FSM_CTX_ARB_STATS_EN
        stats_sel = '0;
        drive(0, 2'd0, 1'b0);
        repeat (70000) tick();
        idle();
        tick(); check("stats.sat", 32'(stats_cnt), 32'hFFFF);
        ctx_clear[0] = 1'b1;
        tick(); check("stats.clr", 32'(stats_cnt), 32'd0);
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
